// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - two-port round-robin arbiter in front of a single-port data RAM
module data_ram_arbiter #(
    parameter int DW    = 16,
    parameter int AW    = 16,
    parameter int DEPTH = 256
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    state_t state;
    state_t nextState;
    logic   weLatched;
    logic   prio;       // 0: port 0 wins a tie, 1: port 1 wins a tie
    logic   pick1;
    logic   inRange;

    assign pick1   = req1 & (~req0 | prio);
    assign inRange = ({1'b0, ram_addr} < DEPTH_LIM);
    assign ram_we  = (state == ACCESS) & weLatched & inRange;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (req0 | req1) nextState = ACCESS;
            ACCESS:  nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            ram_addr  <= '0;
            ram_din   <= '0;
            weLatched <= 1'b0;
            prio      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        if (pick1) begin
                            ram_addr  <= addr1;
                            ram_din   <= wdata1;
                            weLatched <= we1;
                            gnt1      <= 1'b1;
                            prio      <= 1'b0;
                        end else begin
                            ram_addr  <= addr0;
                            ram_din   <= wdata0;
                            weLatched <= we0;
                            gnt0      <= 1'b1;
                            prio      <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    // ram_dout is sampled before the RAM applies this edge's write
                    rdata <= inRange ? ram_dout : '0;
                    err   <= ~inRange;
                    ack0  <= gnt0;
                    ack1  <= gnt1;
                end
                DONE: begin
                    gnt0 <= 1'b0;
                    gnt1 <= 1'b0;
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    err  <= 1'b0;
                end
                default: begin
                    gnt0 <= 1'b0;
                    gnt1 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - self-checking bench for data_ram_arbiter
module tb_data_ram_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, ack0, ack1, err, ram_we;
    logic [15:0] rdata, ram_addr, ram_din, ram_dout;

    int checks = 0;
    int errors = 0;

    data_ram_arbiter #(.DW(16), .AW(16), .DEPTH(256)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata(rdata), .err(err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 CLK = ~CLK;

    // Bench-side data RAM, preloaded through its own port while RST is high
    logic        preload = 1'b0;
    logic [7:0]  preIdx = '0;
    logic [15:0] preVal = '0;
    logic [15:0] ram [0:255];

    always @(posedge CLK) begin
        if (preload) ram[preIdx] <= preVal;
        else if (ram_we) ram[ram_addr[7:0]] <= ram_din;
    end
    assign ram_dout = (ram_addr < 16'd256) ? ram[ram_addr[7:0]] : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one access occupies edges start..start+2,
    // memory effect and read capture land on edge start+1.
    logic [15:0] mMem [0:255];
    int          edgeNo = 0, start = 0, nextArb = 0;
    logic        active = 0, prioM = 0, win = 0, mWe = 0;
    logic [15:0] mAddr = 0, mDin = 0, expRdata = 0;
    logic        expErr = 0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            if (preload && CLK) mMem[preIdx] = preVal;
            active = 0; prioM = 0; mAddr = 0; mDin = 0; mWe = 0;
            expRdata = 0; expErr = 0; nextArb = edgeNo;
        end else begin
            edgeNo++;
            if (active && edgeNo == start + 1) begin
                expErr   = !(mAddr < 16'd256);
                expRdata = expErr ? 16'h0000 : mMem[mAddr[7:0]];
                if (mWe && !expErr) mMem[mAddr[7:0]] = mDin;
            end
            if (active && edgeNo >= start + 2) active = 0;
            if (edgeNo >= nextArb && (req0 || req1)) begin
                win     = (req0 && req1) ? prioM : req1;
                mAddr   = win ? addr1 : addr0;
                mDin    = win ? wdata1 : wdata0;
                mWe     = win ? we1 : we0;
                prioM   = !win;
                active  = 1;
                start   = edgeNo;
                nextArb = edgeNo + 3;
            end
        end
    end

    logic cmpEn = 0;
    always @(negedge CLK) begin
        if (cmpEn) begin
            int   d;
            logic eg, ea, ew;
            d  = edgeNo - start;
            eg = active && d <= 1;
            ea = active && d == 1;
            ew = active && d == 0 && mWe && (mAddr < 16'd256);
            chk("gnt0", 32'(gnt0), 32'(eg && !win));
            chk("gnt1", 32'(gnt1), 32'(eg && win));
            chk("ack0", 32'(ack0), 32'(ea && !win));
            chk("ack1", 32'(ack1), 32'(ea && win));
            chk("ram_we", 32'(ram_we), 32'(ew));
            chk("err", 32'(err), 32'(ea && expErr));
            chk("rdata", 32'(rdata), 32'(expRdata));
            chk("ram_addr", 32'(ram_addr), 32'(mAddr));
            chk("ram_din", 32'(ram_din), 32'(mDin));
        end
    end

    task automatic doAccess(input int p, input logic w, input logic [15:0] a, input logic [15:0] dat,
                            output int gC, output int aC, output int wC, output int aIdx,
                            output logic [15:0] rd, output logic [15:0] wA, output logic er);
        gC = 0; aC = 0; wC = 0; aIdx = -1; rd = 0; wA = 0; er = 0;
        @(negedge CLK);
        if (p == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = dat; end
        else begin req1 = 1; we1 = w; addr1 = a; wdata1 = dat; end
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                req0 = 0; req1 = 0; we0 = !w; we1 = !w;
                addr0 = 16'h00F3; addr1 = 16'h00F4; wdata0 = 16'h1234; wdata1 = 16'h4321;
            end
            if (p == 0 ? gnt0 : gnt1) gC++;
            if (p == 0 ? ack0 : ack1) begin
                aC++;
                if (aIdx < 0) aIdx = i;
                rd = rdata; er = err;
            end
            if (ram_we) begin wC++; wA = ram_addr; end
        end
    endtask

    initial begin
        int gC, aC, wC, aIdx;
        logic [15:0] rd, wA;
        logic er;
        int gp[$];
        int gt[$];
        logic pg0, pg1;

        RST = 1;
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            preload = 1; preIdx = 8'(i); preVal = 16'h1000 + 16'(i);
        end
        @(negedge CLK);
        preload = 0;
        chk("rst_gnt0", 32'(gnt0), 0);
        chk("rst_ack1", 32'(ack1), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_din", 32'(ram_din), 0);
        chk("rst_err", 32'(err), 0);
        RST = 0;
        cmpEn = 1;

        // Both ports request continuously: alternating grants, 3 cycles apart
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 16'h0005; addr1 = 16'h0006;
        pg0 = 0; pg1 = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            if (gnt0 && !pg0) begin gp.push_back(0); gt.push_back(i); end
            if (gnt1 && !pg1) begin gp.push_back(1); gt.push_back(i); end
            pg0 = gnt0; pg1 = gnt1;
        end
        req0 = 0; req1 = 0;
        chk("rr_count_ge4", 32'(gp.size() >= 4), 1);
        if (gp.size() >= 4) begin
            for (int k = 0; k < 4; k++) chk("rr_order", 32'(gp[k]), 32'(k % 2));
            chk("rr_first_at_E0", 32'(gt[0]), 0);
            for (int k = 1; k < 4; k++) chk("rr_spacing", 32'(gt[k] - gt[k-1]), 3);
        end
        repeat (3) @(negedge CLK);

        // Port 0 writes 0xBEEF to 0x0010
        doAccess(0, 1, 16'h0010, 16'hBEEF, gC, aC, wC, aIdx, rd, wA, er);
        chk("wr_gnt_cycles", 32'(gC), 2);
        chk("wr_we_cycles", 32'(wC), 1);
        chk("wr_we_addr", 32'(wA), 32'h0010);
        chk("wr_ack_cycles", 32'(aC), 1);
        chk("wr_err", 32'(er), 0);
        chk("wr_prewrite_rdata", 32'(rd), 32'h1010);

        // Port 1 reads it back
        doAccess(1, 0, 16'h0010, 16'h0000, gC, aC, wC, aIdx, rd, wA, er);
        chk("rd_ack_cycles", 32'(aC), 1);
        chk("rd_ack_latency", 32'(aIdx), 1);
        chk("rd_rdata", 32'(rd), 32'hBEEF);
        chk("rd_we_cycles", 32'(wC), 0);

        // Out-of-range write
        doAccess(0, 1, 16'h0100, 16'hAAAA, gC, aC, wC, aIdx, rd, wA, er);
        chk("oor_we_cycles", 32'(wC), 0);
        chk("oor_ack_cycles", 32'(aC), 1);
        chk("oor_err", 32'(er), 1);
        chk("oor_rdata", 32'(rd), 0);

        // Reset in the middle of a write
        @(negedge CLK);
        req1 = 1; we1 = 1; addr1 = 16'h0020; wdata1 = 16'h5555;
        @(negedge CLK);
        req1 = 0;
        chk("abort_we_before", 32'(ram_we), 1);
        #2 RST = 1;
        #1;
        chk("abort_we_dropped", 32'(ram_we), 0);
        chk("abort_gnt1_dropped", 32'(gnt1), 0);
        @(negedge CLK);
        chk("abort_no_ack", 32'(ack1), 0);
        RST = 0;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 16'h0020; addr1 = 16'h0030;
        @(negedge CLK);
        req0 = 0; req1 = 0;
        chk("abort_next_gnt0", 32'(gnt0), 1);
        chk("abort_next_gnt1", 32'(gnt1), 0);
        @(negedge CLK);
        chk("abort_ack0", 32'(ack0), 1);
        chk("abort_word_unchanged", 32'(rdata), 32'h1020);
        repeat (4) @(negedge CLK);

        cmpEn = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
